// File: rtl/sd_pkg.sv
// Shared definitions for the SD block-buffer arbiter: requester IDs,
// ownership state encodings and default buffer geometry.
package sd_pkg;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int SD_BUF_ADDR_W = 10;
  localparam int SD_BUF_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sd_lock_timer.sv
// Lock-duration counter. It counts the cycles spent locked, and 'expired' flags
// the cycle that would bring the count to LOCK_MAX.
module sd_lock_timer #(
  parameter int LOCK_MAX = 1024
) (
  input  logic iclk,
  input  logic irst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOCK_MAX - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && !clr && (cnt == LAST_CNT);

endmodule

// File: rtl/sd_buf_arbiter.sv
// Round-robin arbiter with burst locking between the SD data-line engine (A)
// and the OTP engine (B) for the single-port buffer RAM. Build option
// SD_ARB_LOCK_TIMEOUT_EN adds a lock timeout that drives oerr.
//
// state  | meaning
// IDLE   | no lock held, round-robin between A and B
// LOCK_A | A owns the RAM, B is held off
// LOCK_B | B owns the RAM, A is held off
import sd_pkg::*;

module sd_buf_arbiter #(
  parameter int ADDR_W   = SD_BUF_ADDR_W,
  parameter int DATA_W   = SD_BUF_DATA_W,
  parameter int LOCK_MAX = 1024
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ia_req,
  input  logic              ia_lock,
  input  logic              ia_we,
  input  logic [ADDR_W-1:0] ia_addr,
  input  logic [DATA_W-1:0] ia_wdata,
  input  logic              ib_req,
  input  logic              ib_lock,
  input  logic              ib_we,
  input  logic [ADDR_W-1:0] ib_addr,
  input  logic [DATA_W-1:0] ib_wdata,
  output logic              oa_gnt,
  output logic              ob_gnt,
  output logic              oa_rvalid,
  output logic              ob_rvalid,
  output logic [DATA_W-1:0] ordata,
  output logic              oram_en,
  output logic              oram_we,
  output logic [ADDR_W-1:0] oram_addr,
  output logic [DATA_W-1:0] oram_wdata,
  input  logic [DATA_W-1:0] iram_rdata,
  output logic              obusy,
  output logic              oerr
);

  arb_state_t state;
  logic       last;
  logic       a_gnt, b_gnt;
  logic       rd_pend1, rd_tag1;
  logic       rd_pend2, rd_tag2;
  logic       err;

`ifdef SD_ARB_LOCK_TIMEOUT_EN
  logic expired;

  sd_lock_timer #(.LOCK_MAX(LOCK_MAX)) u_lock_timer (
    .iclk    (iclk),
    .irst    (irst),
    .clr     (state == IDLE),
    .en      (state != IDLE),
    .expired (expired)
  );
`else
  // LOCK_MAX only matters when the timeout is built in.
  logic unused_lock_max;
  assign unused_lock_max = ^LOCK_MAX;
`endif

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    case (state)
      LOCK_A: a_gnt = ia_req;
      LOCK_B: b_gnt = ib_req;
      default: begin
        if (ia_req && ib_req) begin
          a_gnt = (last == REQ_B);
          b_gnt = (last == REQ_A);
        end else begin
          a_gnt = ia_req;
          b_gnt = ib_req;
        end
      end
    endcase
`ifdef SD_ARB_LOCK_TIMEOUT_EN
    if (expired) begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end
`endif
    if (irst) begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state      <= IDLE;
      last       <= REQ_B;
      err        <= 1'b0;
      oram_en    <= 1'b0;
      oram_we    <= 1'b0;
      oram_addr  <= '0;
      oram_wdata <= '0;
      rd_pend1   <= 1'b0;
      rd_tag1    <= REQ_A;
      rd_pend2   <= 1'b0;
      rd_tag2    <= REQ_A;
    end else begin
      err <= 1'b0;
      if (a_gnt || b_gnt) begin
        last <= b_gnt ? REQ_B : REQ_A;
      end

      case (state)
        IDLE: begin
          if (a_gnt && ia_lock) begin
            state <= LOCK_A;
          end else if (b_gnt && ib_lock) begin
            state <= LOCK_B;
          end
        end
        LOCK_A:  if (!ia_lock) state <= IDLE;
        LOCK_B:  if (!ib_lock) state <= IDLE;
        default: state <= IDLE;
      endcase

`ifdef SD_ARB_LOCK_TIMEOUT_EN
      if (expired) begin
        state <= IDLE;
        err   <= 1'b1;
        last  <= (state == LOCK_B) ? REQ_B : REQ_A;
      end
`endif

      oram_en    <= a_gnt | b_gnt;
      oram_we    <= b_gnt ? ib_we : (a_gnt & ia_we);
      oram_addr  <= b_gnt ? ib_addr : ia_addr;
      oram_wdata <= b_gnt ? ib_wdata : ia_wdata;

      // Read tag travels with the access, then lines up with iram_rdata.
      rd_pend1 <= (a_gnt & ~ia_we) | (b_gnt & ~ib_we);
      rd_tag1  <= b_gnt ? REQ_B : REQ_A;
      rd_pend2 <= rd_pend1;
      rd_tag2  <= rd_tag1;
    end
  end

  assign oa_gnt    = a_gnt;
  assign ob_gnt    = b_gnt;
  assign oa_rvalid = rd_pend2 & (rd_tag2 == REQ_A);
  assign ob_rvalid = rd_pend2 & (rd_tag2 == REQ_B);
  assign ordata    = rd_pend2 ? iram_rdata : '0;
  assign obusy     = (state != IDLE);
  assign oerr      = err;

endmodule

// File: doc/sd_buf_arbiter.md
# sd_buf_arbiter

Shares the single-port SD block buffer RAM (one 512-byte sector, held as 1024 × 4-bit nibbles) between two requesters. Requester A is the SD data-line engine, which fills the buffer on READ and drains it on WRITE. Requester B is the OTP engine, which XORs pad nibbles in place between READ and CMD24. The block sits between those two engines and the buffer RAM. It provides round-robin fairness and burst locking, and registers every RAM port signal.

## Interface
Parameters:
- ADDR_W, 10, buffer address width (nibble index).
- DATA_W, 4, buffer data width (matches the 4-bit SD bus).
- LOCK_MAX, 1024, maximum lock length in cycles; used only with the timeout feature.

Ports:
- iclk  in  1  clock
- irst  in  1  reset; **asynchronous, active-high**
- ia_req / ib_req  in  1  access request; held with its fields until granted
- ia_lock / ib_lock  in  1  keep ownership after this access
- ia_we / ib_we  in  1  1 = write, 0 = read
- ia_addr / ib_addr  in  ADDR_W  nibble address
- ia_wdata / ib_wdata  in  DATA_W  write data
- oa_gnt / ob_gnt  out  1  access accepted this cycle (combinational)
- oa_rvalid / ob_rvalid  out  1  ordata belongs to this requester
- ordata  out  DATA_W  read data, shared by both requesters
- oram_en, oram_we  out  1  RAM port enable and write enable (registered)
- oram_addr  out  ADDR_W  RAM address (registered)
- oram_wdata  out  DATA_W  RAM write data (registered)
- iram_rdata  in  DATA_W  synchronous RAM read data, valid 1 cycle after oram_en
- obusy  out  1  lock held by either requester
- oerr  out  1  lock-timeout pulse

## Operation
- Ownership FSM has three states:
  - IDLE: no lock held.
  - LOCK_A, LOCK_B: the named requester owns the RAM.
- Round-robin pointer `last` records the last granted requester.
- Grant rule, evaluated each cycle:
  - LOCK_A: only A may be granted (if ia_req); ob_gnt = 0.
  - LOCK_B: only B may be granted (if ib_req); oa_gnt = 0.
  - IDLE, single requester: that requester is granted.
  - IDLE, both requesting: the requester that is not `last` is granted.
- At most one grant per cycle, and oa_gnt & ob_gnt is never 1.
- Lock transitions:
  - IDLE → LOCK_x when x is granted with ix_lock = 1.
  - LOCK_x → IDLE when x is granted with ix_lock = 0, or when ix_req = 0 and ix_lock = 0.
  - LOCK_x with ix_req = 0 and ix_lock = 1 stays locked; the idle cycle is wasted by design.
- `last` updates on every grant.
- A granted access is registered onto the oram_* signals at the next edge. oram_en = 0 in cycles with no grant.
- A read tag (requester ID) is pipelined alongside the access. ix_rvalid = 1 and ordata = iram_rdata in the cycle after oram_en for reads only. Writes never produce rvalid.
- obusy = (state != IDLE).
- Reset values:
  - All outputs 0.
  - state = IDLE, last = B, so A wins the first tie.
  - Pipelined read tags are cleared.
- Reset mid-burst: the lock is dropped, and in-flight read data is discarded (no rvalid).

## Timing
- Grant → oram_* valid: 1 cycle.
- Grant → ix_rvalid/ordata: 2 cycles.
- Back-to-back grants to one owner sustain 1 access per cycle.
- Hand-off between requesters in IDLE costs no bubble: A in cycle t, B in cycle t+1.
- Read and write issued in consecutive cycles are both honoured. The RAM sees them in order, with no read-after-write forwarding.

## Configuration
- SD_ARB_LOCK_TIMEOUT_EN defined:
  - A cycle counter (width clog2(LOCK_MAX+1)) runs while in LOCK_x and clears on entering IDLE.
  - When it reaches LOCK_MAX, the FSM is forced to IDLE and oerr pulses for 1 cycle.
  - `last` is set to x, so the other requester wins the next tie.
- SD_ARB_LOCK_TIMEOUT_EN undefined:
  - The counter is absent, oerr is tied to 0, and LOCK_MAX is ignored.
  - Locks are held indefinitely.

## Structure
- Shared package sd_pkg holds:
  - requester IDs (REQ_A = 1'b0, REQ_B = 1'b1);
  - FSM state encodings (IDLE, LOCK_A, LOCK_B);
  - default widths SD_BUF_ADDR_W = 10 and SD_BUF_DATA_W = 4.
- Sub-module sd_lock_timer: the timeout counter with clear, enable, and `expired` output. It is instantiated only under SD_ARB_LOCK_TIMEOUT_EN.

## Test plan
- **Reset.** Assert irst mid-burst in LOCK_B with a read in flight → all outputs 0 and no rvalid; after release, the first A/B tie grants A.
- **Tie, no lock.** ia_req and ib_req held for 4 cycles with lock = 0 → grants alternate A, B, A, B; each read produces rvalid exactly 2 cycles after its grant with the correct requester tag.
- **Locked burst.** A writes 0x0..0xF to addresses 0..15 with ia_lock = 1 and ia_lock = 0 on the last access, while ib_req is held → ob_gnt = 0 for all 16 cycles; B is granted in the cycle after A's last grant; obusy falls with the last grant.
- **Read/write ordering.** B writes 0x5 to address 0x3FF, then reads 0x3FF in the next cycle → ob_rvalid with ordata = 0x5.
- **Lock idle hold.** A holds ia_lock = 1 with ia_req = 0 for 10 cycles while B requests → no grant to B until ia_lock falls; B is granted the following cycle.
- **Timeout (SD_ARB_LOCK_TIMEOUT_EN, LOCK_MAX = 8).** A locks and stalls → oerr pulses once 8 cycles after lock entry, the state returns to IDLE, and a pending B request is granted on the next cycle.
